// File: rtl/reg_writeback.sv
// Write-side companion to the register file: an in-order queue of pending writes drained one per
// cycle into a registered write port, with combinational forwarding over uncommitted entries.
module reg_writeback #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         regWrite,
  input  logic [ADDR_WIDTH-1:0]        writeRegister,
  input  logic [DATA_WIDTH-1:0]        writeData,
  output logic                         ready,
  input  logic [ADDR_WIDTH-1:0]        register1,
  input  logic [ADDR_WIDTH-1:0]        register2,
  output logic                         hit1,
  output logic                         hit2,
  output logic [DATA_WIDTH-1:0]        fwdData1,
  output logic [DATA_WIDTH-1:0]        fwdData2,
  output logic                         rfWrite,
  output logic [ADDR_WIDTH-1:0]        rfRegister,
  output logic [DATA_WIDTH-1:0]        rfData,
  input  logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PtrW-1:0]       head_q, tail_q;
  logic [CntW-1:0]       count_q;
  logic                  push, pop;

  assign ready   = (count_q < CntW'(DEPTH));
  assign pending = count_q;

  // Writes to ZR complete the handshake but never occupy a slot.
  assign push = regWrite && ready && (writeRegister != '0);
  assign pop  = !stall && (count_q != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= writeRegister;
      data_q[tail_q] <= writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rfWrite    <= 1'b0;
      rfRegister <= '0;
      rfData     <= '0;
    end else begin
      if (push) tail_q <= tail_q + PtrW'(1);
      if (pop)  head_q <= head_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      // A stalled output stage holds; rfRegister/rfData also hold when idle.
      if (!stall) begin
        rfWrite <= pop;
        if (pop) begin
          rfRegister <= addr_q[head_q];
          rfData     <= data_q[head_q];
        end
      end
    end
  end

  // Scan oldest to newest so the last match wins: output stage, then head .. tail-1.
  function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] r);
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
    logic [PtrW-1:0]       idx;
    hit  = 1'b0;
    data = '0;
    if (rfWrite && (rfRegister == r)) begin
      hit  = 1'b1;
      data = rfData;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (addr_q[idx] == r)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
    if (r == '0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {hit1, fwdData1} = lookup(register1);
    {hit2, fwdData2} = lookup(register2);
  end

endmodule
